// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction-fetch block: memory latency,
//   output buffer depth, the canonical NOP encoding, the default reset PC
//   and the {instr, pc} entry type carried through the fetch buffer.
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int          IMEM_LAT         = 1;             // cycles from imem_re to imem_rd
    localparam int          FETCH_BUF_DEPTH  = 2;             // output buffer entries
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013; // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int FETCH_PTR_W = $clog2(FETCH_BUF_DEPTH);
    localparam int FETCH_CNT_W = $clog2(FETCH_BUF_DEPTH + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buf.sv
// ---------------------------------------------------------------------------
// instr_fetch_buf
//   Small FIFO of {instr, pc} entries that absorbs the instruction memory
//   latency while decode is stalled. Flush empties it and wins over a push
//   or pop in the same cycle.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_entry at the tail
//   pop          drop the head entry
//   flush        discard all entries
//   push_entry   entry to write
//   head_entry   oldest entry (meaningful while count != 0)
//   count        number of valid entries, 0..FETCH_BUF_DEPTH
// ---------------------------------------------------------------------------
module instr_fetch_buf
    import instr_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_entry,
    output fetch_entry_t           head_entry,
    output logic [FETCH_CNT_W-1:0] count
);

    fetch_entry_t            mem_reg [FETCH_BUF_DEPTH];
    logic [FETCH_PTR_W-1:0]  rd_ptr_reg;
    logic [FETCH_PTR_W-1:0]  wr_ptr_reg;
    logic [FETCH_CNT_W-1:0]  count_reg;
    logic                    do_push;

    // Depth is a power of two, so the pointers wrap naturally.
    assign do_push = push && !flush && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + FETCH_CNT_W'(push) - FETCH_CNT_W'(pop);
        end
    end

    // Entry storage carries no reset; count_reg alone decides validity.
    generate
        for (genvar gi = 0; gi < FETCH_BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == FETCH_PTR_W'(gi))) begin
                    mem_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

    assign head_entry = mem_reg[rd_ptr_reg];
    assign count      = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch-side initiator for a synchronous instruction memory with one cycle
//   of read latency. Keeps the fetch PC, tracks the single outstanding read,
//   buffers returned words and hands {instr, pc, pc+4} to decode over a
//   valid/ready handshake. Branch/jump redirects restart fetch immediately.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   imem_re, imem_a   read enable and word index to instruction memory
//   imem_rd           read data, valid the cycle after imem_re
//   redirect_valid    restart fetch at redirect_pc (byte address)
//   redirect_pc
//   if_valid/if_ready handshake to decode
//   if_instr, if_pc, if_pc4  instruction, its byte address, address + 4
//   misalign          one-cycle pulse after a redirect with pc[1:0] != 0
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_re,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        misalign
);

    logic [31:0]            fetch_pc_reg;
    logic [31:0]            inflight_pc_reg;
    logic                   inflight_reg;
    logic                   misalign_reg;

    logic [FETCH_CNT_W-1:0] buf_count;
    fetch_entry_t           buf_head;
    fetch_entry_t           ret_entry;
    fetch_entry_t           head_entry;
    logic                   buf_empty;
    logic                   pop;
    logic                   bypass;
    logic                   buf_push;
    logic                   buf_pop;
    logic                   issue;
    logic [31:0]            issue_pc;
    logic [FETCH_CNT_W:0]   occupancy;

    always_comb begin
        issue_pc         = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc_reg;
        ret_entry.instr  = imem_rd;
        ret_entry.pc     = inflight_pc_reg;
        buf_empty        = (buf_count == '0);

        // With an empty buffer the returning word is presented directly, so a
        // read issued in one cycle is visible to decode in the next.
        head_entry       = buf_empty ? ret_entry : buf_head;
        if_valid         = rst_n && (!buf_empty || inflight_reg) && !redirect_valid;
        pop              = if_valid && if_ready;
        bypass           = pop && buf_empty;
        buf_pop          = pop && !buf_empty;
        buf_push         = rst_n && inflight_reg && !bypass && !redirect_valid;

        // Entries that remain after this cycle; a new read is allowed only if
        // its return will still have a slot.
        occupancy        = {1'b0, buf_count} + (FETCH_CNT_W+1)'(inflight_reg)
                         - (FETCH_CNT_W+1)'(pop);
        issue            = rst_n && (redirect_valid ||
                           (occupancy < (FETCH_CNT_W+1)'(FETCH_BUF_DEPTH)));

        imem_re          = issue;
        imem_a           = rst_n ? {2'b00, issue_pc[31:2]} : {2'b00, RESET_PC[31:2]};

        if_instr         = rst_n ? head_entry.instr : '0;
        if_pc            = rst_n ? head_entry.pc : '0;
        if_pc4           = rst_n ? head_entry.pc + 32'd4 : '0;
        misalign         = rst_n && misalign_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_pc_reg <= RESET_PC;
            inflight_reg    <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            // A redirect re-issues immediately, so the old return is simply
            // never pushed and the new read takes over the inflight slot.
            inflight_reg <= issue;
            misalign_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (issue) begin
                inflight_pc_reg <= issue_pc;
                fetch_pc_reg    <= issue_pc + 32'd4;
            end
        end
    end

    instr_fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (buf_push),
        .pop        (buf_pop),
        .flush      (redirect_valid),
        .push_entry (ret_entry),
        .head_entry (buf_head),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Drives instr_fetch against a 1-cycle ROM (mem[i] = A000_0000 | i).
//   A stream model tracks which byte address decode must see next and checks
//   every valid cycle; directed steps pin latency, stall, redirect, misalign,
//   wrap and reset behaviour with literal values.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_re;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        misalign;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_re        (imem_re),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .misalign       (misalign)
    );

    // Synchronous ROM; index aliases naturally into the 32-bit word.
    always @(posedge clk) begin
        if (imem_re) imem_rd <= 32'hA000_0000 | imem_a;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] byte_addr);
        logic [31:0] idx;
        idx = byte_addr >> 2;
        return 32'hA000_0000 | idx;
    endfunction

    // ---------------- stream model ----------------
    logic [31:0] exp_pc = RESET_PC;
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_instr = 32'h0;
    logic        mis_exp = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_imem_re",  32'(imem_re),  32'h0);
            check("rst_if_valid", 32'(if_valid), 32'h0);
            check("rst_if_instr", if_instr, 32'h0);
            check("rst_if_pc",    if_pc,    32'h0);
            check("rst_if_pc4",   if_pc4,   32'h0);
            check("rst_misalign", 32'(misalign), 32'h0);
            check("rst_imem_a",   imem_a,   RESET_PC >> 2);
            exp_pc  = RESET_PC;
            hold_v  = 1'b0;
            mis_exp = 1'b0;
        end else begin
            check("misalign", 32'(misalign), 32'(mis_exp));
            mis_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                check("redir_if_valid", 32'(if_valid), 32'h0);
                check("redir_imem_re",  32'(imem_re),  32'h1);
                check("redir_imem_a",   imem_a, redirect_pc >> 2);
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                hold_v = 1'b0;
                $display("[TB] redirect to %h", redirect_pc);
            end else begin
                if (hold_v) begin
                    check("hold_valid", 32'(if_valid), 32'h1);
                    check("hold_pc",    if_pc,    hold_pc);
                    check("hold_instr", if_instr, hold_instr);
                end
                if (if_valid) begin
                    check("stream_pc",    if_pc,    exp_pc);
                    check("stream_instr", if_instr, rom(exp_pc));
                    check("stream_pc4",   if_pc4,   exp_pc + 32'd4);
                    if (if_ready) begin
                        $display("[TB] xfer pc=%h instr=%h pc4=%h", if_pc, if_instr, if_pc4);
                        exp_pc = exp_pc + 32'd4;
                        hold_v = 1'b0;
                    end else begin
                        hold_v     = 1'b1;
                        hold_pc    = if_pc;
                        hold_instr = if_instr;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic rst_val, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst_n          = rst_val;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        // Test 1: reset release, streaming
        cyc(1, 1, 0, 0);
        check("t1_first_re", 32'(imem_re), 32'h1);
        check("t1_first_a",  imem_a, 32'h0);
        check("t1_first_nv", 32'(if_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0);
            check("t1_valid", 32'(if_valid), 32'h1);
            check("t1_pc", if_pc, 32'(4 * i));
            if (i == 0) begin
                check("t1_instr0", if_instr, 32'hA000_0000);
                check("t1_pc4_0",  if_pc4,   32'h4);
            end
        end
        // Test 2: 5-cycle stall then release
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0);
            check("t2_stall_valid", 32'(if_valid), 32'h1);
            check("t2_stall_pc", if_pc, 32'h10);
            if (i >= 2) check("t2_stall_re", 32'(imem_re), 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0);
            check("t2_resume_valid", 32'(if_valid), 32'h1);
            check("t2_resume_pc", if_pc, 32'(16 + 4 * i));
        end
        // Test 3: fill the buffer, then redirect to 0x40
        cyc(1, 0, 0, 0);
        check("t3_fill_pc", if_pc, 32'h20);
        cyc(1, 0, 0, 0);
        check("t3_full_re", 32'(imem_re), 32'h0);
        cyc(1, 1, 1, 32'h40);
        check("t3_redir_nv", 32'(if_valid), 32'h0);
        check("t3_redir_a",  imem_a, 32'h10);
        cyc(1, 1, 0, 0);
        check("t3_tgt_valid", 32'(if_valid), 32'h1);
        check("t3_tgt_instr", if_instr, 32'hA000_0010);
        check("t3_tgt_pc",    if_pc,    32'h40);
        check("t3_tgt_pc4",   if_pc4,   32'h44);
        cyc(1, 1, 0, 0);
        check("t3_next_pc", if_pc, 32'h44);
        // Test 4: misaligned redirect
        cyc(1, 1, 1, 32'h42);
        check("t4_redir_a", imem_a, 32'h10);
        check("t4_mis_same", 32'(misalign), 32'h0);
        cyc(1, 1, 0, 0);
        check("t4_mis_pulse", 32'(misalign), 32'h1);
        check("t4_pc", if_pc, 32'h40);
        cyc(1, 1, 0, 0);
        check("t4_mis_clear", 32'(misalign), 32'h0);
        check("t4_pc_next", if_pc, 32'h44);
        // Back-to-back redirects: last one wins
        cyc(1, 1, 1, 32'h100);
        cyc(1, 1, 1, 32'h200);
        cyc(1, 1, 0, 0);
        check("b2b_pc",    if_pc,    32'h200);
        check("b2b_instr", if_instr, 32'hA000_0080);
        cyc(1, 1, 0, 0);
        check("b2b_pc_next", if_pc, 32'h204);
        // Test 5: wrap at top of address space
        cyc(1, 1, 1, 32'hFFFF_FFFC);
        check("t5_redir_a", imem_a, 32'h3FFF_FFFF);
        cyc(1, 1, 0, 0);
        check("t5_pc_top",    if_pc,    32'hFFFF_FFFC);
        check("t5_instr_top", if_instr, 32'hBFFF_FFFF);
        check("t5_pc4_top",   if_pc4,   32'h0);
        cyc(1, 1, 0, 0);
        check("t5_pc_wrap",    if_pc,    32'h0);
        check("t5_instr_wrap", if_instr, 32'hA000_0000);
        // Test 6: reset with a buffered entry and a read inflight
        cyc(1, 0, 0, 0);
        check("t6_pre_pc", if_pc, 32'h4);
        cyc(0, 0, 0, 0);
        check("t6_rst_valid", 32'(if_valid), 32'h0);
        check("t6_rst_re",    32'(imem_re),  32'h0);
        cyc(1, 1, 0, 0);
        check("t6_first_re", 32'(imem_re), 32'h1);
        check("t6_first_a",  imem_a, 32'h0);
        check("t6_first_nv", 32'(if_valid), 32'h0);
        cyc(1, 1, 0, 0);
        check("t6_valid", 32'(if_valid), 32'h1);
        check("t6_pc0",    if_pc,    32'h0);
        check("t6_instr0", if_instr, 32'hA000_0000);
        cyc(1, 1, 0, 0);
        check("t6_pc1", if_pc, 32'h4);
        repeat (3) cyc(1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
